apb_arb_master: RTL and testbench

Two-port APB master that shares a single APB slave (the team's APB memory) between two requesters. It accepts one request at a time using a round-robin grant and drives the APB SETUP/ACCESS sequence. It waits for Pready, then returns read data and Pslverr to the winning requester as a one-cycle response pulse. It sits between the two bus clients and the slave's Paddr/Pselx/Penable/Pwrite/Pwdata/Pready/Pslverr/Prdata pins.

---
 rtl/apb_arb_master.sv | 136 +++++++++++++
 tb/tb_apb_arb_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arb_master.sv
// Two-requester APB master with round-robin grant and a one-cycle response pulse.
// Optional ACCESS timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] Paddr,
  output logic              Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [DATA_W-1:0] Pwdata,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic              grant_q;
  logic              any_req;
  logic              gnt;
  logic              timeout;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_err;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);
  logic [CntW-1:0] cnt_q;
  assign timeout = (cnt_q == CntW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout = 1'b0;
`endif

  always_comb begin
    any_req = req0_valid | req1_valid;
    // Contention goes to the port not granted last; a lone requester always wins.
    if (req0_valid && req1_valid) gnt = ~last_grant_q;
    else                          gnt = req1_valid;
    req0_ready = Prst && (state_q == StIdle) && any_req && !gnt;
    req1_ready = Prst && (state_q == StIdle) && any_req && gnt;
    acc_rdata  = (Pready && !Pwrite) ? Prdata : '0;
    acc_err    = Pready ? Pslverr : 1'b1;
  end

  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      Paddr        <= '0;
      Pselx        <= 1'b0;
      Penable      <= 1'b0;
      Pwrite       <= 1'b0;
      Pwdata       <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp0_err     <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_rdata   <= '0;
      rsp1_err     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q      <= StSetup;
            grant_q      <= gnt;
            last_grant_q <= gnt;
            Pselx        <= 1'b1;
            Paddr        <= gnt ? req1_addr  : req0_addr;
            Pwrite       <= gnt ? req1_write : req0_write;
            Pwdata       <= gnt ? req1_wdata : req0_wdata;
          end
        end
        StSetup: begin
          state_q <= StAccess;
          Penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        StAccess: begin
`ifdef APB_ARB_TIMEOUT_EN
          cnt_q <= cnt_q + CntW'(1);
`endif
          if (Pready || timeout) begin
            state_q <= StResp;
            Pselx   <= 1'b0;
            Penable <= 1'b0;
            if (grant_q) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= acc_rdata;
              rsp1_err   <= acc_err;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= acc_rdata;
              rsp0_err   <= acc_err;
            end
          end
        end
        StResp: begin
          state_q    <= StIdle;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: vector table of transfers plus reset-abort and
// ACCESS-timeout sequences (timeout branch follows APB_ARB_TIMEOUT_EN).
module tb_apb_arb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          Pclk = 1'b0;
  logic          Prst;
  logic          req0_valid, req0_write, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_write, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] Paddr;
  logic          Pselx, Penable, Pwrite, Pready, Pslverr;
  logic [DW-1:0] Pwdata, Prdata;

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Pclk       (Pclk),
    .Prst       (Prst),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .Paddr      (Paddr),
    .Pselx      (Pselx),
    .Penable    (Penable),
    .Pwrite     (Pwrite),
    .Pwdata     (Pwdata),
    .Pready     (Pready),
    .Pslverr    (Pslverr),
    .Prdata     (Prdata)
  );

  always #5 Pclk = ~Pclk;

  typedef struct {
    logic        v0, w0;
    logic [31:0] a0, d0;
    logic        v1, w1;
    logic [31:0] a1, d1;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic        gnt;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] hold_rdata[2];
  logic        hold_err[2];
  int          checks   = 0;
  int          failures = 0;
  int          busy_cycles;

  function automatic vec_t mk(input logic v0, input logic w0, input logic [31:0] a0,
                              input logic [31:0] d0, input logic v1, input logic w1,
                              input logic [31:0] a1, input logic [31:0] d1, input int waits,
                              input logic [31:0] prd, input logic se, input logic g,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.waits = waits; v.prdata = prd; v.slverr = se; v.gnt = g;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  task automatic chk_rsp_hold();
    chk("rsp0_rdata", rsp0_rdata, hold_rdata[0]);
    chk("rsp1_rdata", rsp1_rdata, hold_rdata[1]);
    chk("rsp0_err", {31'b0, rsp0_err}, {31'b0, hold_err[0]});
    chk("rsp1_err", {31'b0, rsp1_err}, {31'b0, hold_err[1]});
  endtask

  task automatic run_xfer(input vec_t v);
    logic [31:0] a, d;
    logic        w;
    a = v.gnt ? v.a1 : v.a0;
    d = v.gnt ? v.d1 : v.d0;
    w = v.gnt ? v.w1 : v.w0;
    req0_valid = v.v0; req0_write = v.w0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_write = v.w1; req1_addr = v.a1; req1_wdata = v.d1;
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    #1;
    chk("accept_ready0", {31'b0, req0_ready}, {31'b0, ~v.gnt});
    chk("accept_ready1", {31'b0, req1_ready}, {31'b0, v.gnt});
    chk("idle_pselx", {31'b0, Pselx}, 32'd0);
    step();
    // Pready high in SETUP must not shorten the transfer.
    Pready = 1'b1;
    chk("setup_pselx", {31'b0, Pselx}, 32'd1);
    chk("setup_penable", {31'b0, Penable}, 32'd0);
    chk("setup_paddr", Paddr, a);
    chk("setup_pwrite", {31'b0, Pwrite}, {31'b0, w});
    if (w) chk("setup_pwdata", Pwdata, d);
    chk("busy_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    step();
    for (int i = 0; i < v.waits; i++) begin
      Pready = 1'b0;
      chk("wait_penable", {31'b0, Penable}, 32'd1);
      chk("wait_paddr", Paddr, a);
      chk("wait_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      step();
    end
    Pready = 1'b1; Prdata = v.prdata; Pslverr = v.slverr;
    chk("access_pselx", {31'b0, Pselx}, 32'd1);
    chk("access_penable", {31'b0, Penable}, 32'd1);
    chk("access_paddr", Paddr, a);
    chk("busy_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    step();
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    hold_rdata[int'(v.gnt)] = v.exp_rdata;
    hold_err[int'(v.gnt)]   = v.exp_err;
    chk("resp_valid0", {31'b0, rsp0_valid}, {31'b0, ~v.gnt});
    chk("resp_valid1", {31'b0, rsp1_valid}, {31'b0, v.gnt});
    chk_rsp_hold();
    chk("resp_psel_pen", {30'b0, Pselx, Penable}, 32'd0);
    chk("busy_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("idle_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk_rsp_hold();
  endtask

  initial begin
    vecs[0] = mk(1'b1, 1'b1, 32'h5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0,
                 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[1] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h5, 32'h0,
                 3, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    vecs[2] = mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234,
                 0, 32'hA5A50001, 1'b0, 1'b0, 32'hA5A50001, 1'b0);
    vecs[3] = mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234,
                 0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 1'b1);
    vecs[4] = mk(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 32'h24, 32'h5678,
                 1, 32'h0BADF00D, 1'b0, 1'b0, 32'h0BADF00D, 1'b0);
    vecs[5] = mk(1'b1, 1'b1, 32'h18, 32'h9999, 1'b1, 1'b0, 32'h28, 32'h0,
                 2, 32'h55AA, 1'b1, 1'b1, 32'h55AA, 1'b1);
    vecs[6] = mk(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                 0, 32'h77, 1'b0, 1'b0, 32'h77, 1'b0);
    vecs[7] = mk(1'b1, 1'b1, 32'h34, 32'hABCD, 1'b0, 1'b0, 32'h0, 32'h0,
                 0, 32'h88, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[8] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h38, 32'hEF,
                 1, 32'h99, 1'b0, 1'b1, 32'h0, 1'b0);
    hold_rdata[0] = '0; hold_rdata[1] = '0;
    hold_err[0] = 1'b0; hold_err[1] = 1'b0;

    Prst = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    #2;
    chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    chk("rst_apb_ctl", {29'b0, Pselx, Penable, Pwrite}, 32'd0);
    chk("rst_paddr", Paddr, 32'd0);
    chk("rst_pwdata", Pwdata, 32'd0);
    chk("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk_rsp_hold();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();
    Prst = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_xfer(vecs[i]);

    // Reset during ACCESS of a req0 transfer; afterwards req0 must win contention again.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h40;
    #1;
    chk("abort_accept", {31'b0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    Pready = 1'b0;
    chk("abort_penable", {31'b0, Penable}, 32'd1);
    #2;
    Prst = 1'b0;
    #1;
    hold_rdata[0] = '0; hold_rdata[1] = '0;
    hold_err[0] = 1'b0; hold_err[1] = 1'b0;
    chk("abort_psel_pen", {30'b0, Pselx, Penable}, 32'd0);
    chk("abort_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("abort_paddr", Paddr, 32'd0);
    chk_rsp_hold();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("abort_rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    step();
    step();
    Prst = 1'b1;
    run_xfer(mk(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0,
                0, 32'h1111, 1'b0, 1'b0, 32'h1111, 1'b0));

    // Slave never raises Pready.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h50;
    Prdata = 32'hFFFFFFFF;
    #1;
    chk("stall_accept", {31'b0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    Pready = 1'b0;
    step();
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      chk("to_penable", {31'b0, Penable}, 32'd1);
      chk("to_no_rsp", {31'b0, rsp0_valid}, 32'd0);
      step();
    end
    chk("to_rsp_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("to_rsp_err", {31'b0, rsp0_err}, 32'd1);
    chk("to_rsp_rdata", rsp0_rdata, 32'd0);
    chk("to_psel_pen", {30'b0, Pselx, Penable}, 32'd0);
    step();
    chk("to_rsp_done", {31'b0, rsp0_valid}, 32'd0);
`else
    busy_cycles = 0;
    for (int i = 0; i < 120; i++) begin
      if (Penable && !rsp0_valid) busy_cycles++;
      step();
    end
    chk("stall_penable_cycles", busy_cycles, 32'd120);
    Pready = 1'b1; Prdata = 32'h1357;
    step();
    Pready = 1'b0;
    chk("stall_rsp_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("stall_rsp_rdata", rsp0_rdata, 32'h1357);
    chk("stall_rsp_err", {31'b0, rsp0_err}, 32'd0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
